// File: rtl/mem_access_unit_if.sv
// Request and data-bus signal bundle for mem_access_unit.
// The slave view belongs to the unit; the master view belongs to the CPU/bus environment.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        MemRW;
   logic [1:0]  DataWSel;
   logic [2:0]  DataRSel;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        done;
   logic [31:0] rdata;
   logic        misalign_err;
   logic        bus_err;

   modport slave (
      input  req_valid, MemRW, DataWSel, DataRSel, addr, wdata, bus_ack, bus_rdata,
      output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
             done, rdata, misalign_err, bus_err
   );

   modport master (
      output req_valid, MemRW, DataWSel, DataRSel, addr, wdata, bus_ack, bus_rdata,
      input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
             done, rdata, misalign_err, bus_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one word-addressed bus access per request, with byte enables,
// lane extraction and sign/zero extension of load data, misalign and timeout reporting.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input logic              clk,
   input logic              rst,
   mem_access_unit_if.slave mif
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      state;
   state_t      next_state;
   size_t       acc_size;
   logic        accept;
   logic        aligned;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] lane_word;
   logic [31:0] load_ext;
   logic [7:0]  tmo_cnt;
   logic        we_q;
   logic [2:0]  rsel_q;
   logic [1:0]  lane_q;
   logic        misalign_q;
   logic        timeout_q;
   logic [31:0] bus_addr_q;
   logic [3:0]  bus_be_q;
   logic [31:0] bus_wdata_q;
   logic [31:0] rdata_q;

   assign accept = mif.req_valid && (state == IDLE);

   // Access width comes from DataWSel for stores and DataRSel for loads.
   always_comb begin
      acc_size = SZ_WORD;
      if (mif.MemRW) begin
         case (mif.DataWSel)
            2'b01:   acc_size = SZ_BYTE;
            2'b11:   acc_size = SZ_HALF;
            default: acc_size = SZ_WORD;
         endcase
      end else begin
         case (mif.DataRSel)
            3'b001, 3'b011: acc_size = SZ_BYTE;
            3'b010, 3'b100: acc_size = SZ_HALF;
            default:        acc_size = SZ_WORD;
         endcase
      end
   end

   always_comb begin
      aligned    = 1'b1;
      be_next    = 4'b1111;
      wdata_next = mif.wdata;
      case (acc_size)
         SZ_BYTE: begin
            be_next    = 4'b0001 << mif.addr[1:0];
            wdata_next = {4{mif.wdata[7:0]}};
         end
         SZ_HALF: begin
            aligned    = ~mif.addr[0];
            be_next    = mif.addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{mif.wdata[15:0]}};
         end
         default: begin
            aligned    = (mif.addr[1:0] == 2'b00);
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = aligned ? BUS : RESP;
         BUS:  if (mif.bus_ack || (tmo_cnt == TMO_LAST)) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign lane_word = mif.bus_rdata >> {lane_q, 3'b000};

   always_comb begin
      load_ext = lane_word;
      case (rsel_q)
         3'b001:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
         3'b011:  load_ext = {24'h0, lane_word[7:0]};
         3'b010:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
         3'b100:  load_ext = {16'h0, lane_word[15:0]};
         default: load_ext = lane_word;
      endcase
   end

   // Bus fields are only reloaded for aligned requests, so they stay stable through BUS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q        <= 1'b0;
         rsel_q      <= 3'b000;
         lane_q      <= 2'b00;
         misalign_q  <= 1'b0;
         timeout_q   <= 1'b0;
         tmo_cnt     <= 8'h00;
         bus_addr_q  <= 32'h0;
         bus_be_q    <= 4'h0;
         bus_wdata_q <= 32'h0;
         rdata_q     <= 32'h0;
      end else if (accept) begin
         we_q       <= mif.MemRW;
         rsel_q     <= mif.DataRSel;
         lane_q     <= mif.addr[1:0];
         misalign_q <= ~aligned;
         timeout_q  <= 1'b0;
         tmo_cnt    <= 8'h00;
         if (aligned) begin
            bus_addr_q  <= {mif.addr[31:2], 2'b00};
            bus_be_q    <= be_next;
            bus_wdata_q <= wdata_next;
         end
      end else if (state == BUS) begin
         if (mif.bus_ack) begin
            if (!we_q) rdata_q <= load_ext;
         end else begin
            tmo_cnt <= tmo_cnt + 8'h01;
            if (tmo_cnt == TMO_LAST) timeout_q <= 1'b1;
         end
      end
   end

   assign mif.req_ready    = (state == IDLE);
   assign mif.bus_req      = (state == BUS);
   assign mif.bus_we       = (state == BUS) && we_q;
   assign mif.bus_addr     = bus_addr_q;
   assign mif.bus_be       = bus_be_q;
   assign mif.bus_wdata    = bus_wdata_q;
   assign mif.done         = (state == RESP);
   assign mif.rdata        = rdata_q;
   assign mif.misalign_err = (state == RESP) && misalign_q;
   assign mif.bus_err      = (state == RESP) && timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mem_access_unit;

   logic clk;
   logic rst;
   int   checks;
   int   passed;
   int   high_cnt;

   mem_access_unit_if mif ();

   mem_access_unit #(.TIMEOUT_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and returns 1ns after the accepting edge.
   task automatic applyStimulus(input logic rw, input logic [1:0] wsel, input logic [2:0] rsel,
                                input logic [31:0] a, input logic [31:0] wd);
      mif.MemRW     = rw;
      mif.DataWSel  = wsel;
      mif.DataRSel  = rsel;
      mif.addr      = a;
      mif.wdata     = wd;
      mif.req_valid = 1'b1;
      tick();
      mif.req_valid = 1'b0;
   endtask

   initial begin
      checks        = 0;
      passed        = 0;
      rst           = 1'b1;
      mif.req_valid = 1'b0;
      mif.MemRW     = 1'b0;
      mif.DataWSel  = 2'b00;
      mif.DataRSel  = 3'b000;
      mif.addr      = 32'h0;
      mif.wdata     = 32'h0;
      mif.bus_ack   = 1'b0;
      mif.bus_rdata = 32'h0;
      tick();
      tick();
      checkOutput("rst_req_ready", 32'(mif.req_ready), 32'd1);
      checkOutput("rst_bus_req",   32'(mif.bus_req), 32'd0);
      checkOutput("rst_done",      32'(mif.done), 32'd0);
      checkOutput("rst_bus_be",    32'(mif.bus_be), 32'd0);
      checkOutput("rst_rdata",     mif.rdata, 32'h0);
      #4 rst = 1'b0;
      tick();

      // Load word with three wait cycles; ack lands on the timeout boundary and must win.
      applyStimulus(1'b0, 2'b00, 3'b000, 32'h0000_0100, 32'h0);
      checkOutput("lw_bus_req",   32'(mif.bus_req), 32'd1);
      checkOutput("lw_req_ready", 32'(mif.req_ready), 32'd0);
      checkOutput("lw_bus_we",    32'(mif.bus_we), 32'd0);
      checkOutput("lw_bus_be",    32'(mif.bus_be), 32'hF);
      checkOutput("lw_bus_addr",  mif.bus_addr, 32'h0000_0100);
      repeat (3) tick();
      checkOutput("lw_no_early_done", 32'(mif.done), 32'd0);
      mif.bus_ack   = 1'b1;
      mif.bus_rdata = 32'hDEAD_BEEF;
      tick();
      mif.bus_ack   = 1'b0;
      checkOutput("lw_done",    32'(mif.done), 32'd1);
      checkOutput("lw_bus_err", 32'(mif.bus_err), 32'd0);
      checkOutput("lw_rdata",   mif.rdata, 32'hDEAD_BEEF);
      tick();
      checkOutput("lw_done_once", 32'(mif.done), 32'd0);
      checkOutput("lw_ready",     32'(mif.req_ready), 32'd1);

      // Signed byte load from the top lane.
      applyStimulus(1'b0, 2'b00, 3'b001, 32'h0000_0103, 32'h0);
      checkOutput("lb_bus_be",   32'(mif.bus_be), 32'h8);
      checkOutput("lb_bus_addr", mif.bus_addr, 32'h0000_0100);
      mif.bus_ack   = 1'b1;
      mif.bus_rdata = 32'h80FF_7F01;
      tick();
      mif.bus_ack   = 1'b0;
      checkOutput("lb_done",  32'(mif.done), 32'd1);
      checkOutput("lb_rdata", mif.rdata, 32'hFFFF_FF80);
      tick();

      // Unsigned byte load, same address and data.
      applyStimulus(1'b0, 2'b00, 3'b011, 32'h0000_0103, 32'h0);
      checkOutput("lbu_bus_be", 32'(mif.bus_be), 32'h8);
      mif.bus_ack = 1'b1;
      tick();
      mif.bus_ack = 1'b0;
      checkOutput("lbu_rdata", mif.rdata, 32'h0000_0080);
      tick();

      // Signed half from the upper half of the same word.
      applyStimulus(1'b0, 2'b00, 3'b010, 32'h0000_0102, 32'h0);
      checkOutput("lh_bus_be", 32'(mif.bus_be), 32'hC);
      mif.bus_ack = 1'b1;
      tick();
      mif.bus_ack = 1'b0;
      checkOutput("lh_rdata", mif.rdata, 32'hFFFF_80FF);
      tick();

      // Unsigned half from the lower half.
      applyStimulus(1'b0, 2'b00, 3'b100, 32'h0000_0100, 32'h0);
      checkOutput("lhu_bus_be", 32'(mif.bus_be), 32'h3);
      mif.bus_ack = 1'b1;
      tick();
      mif.bus_ack = 1'b0;
      checkOutput("lhu_rdata", mif.rdata, 32'h0000_7F01);
      tick();

      // Zero-wait half store; rdata must keep the previous load value.
      applyStimulus(1'b1, 2'b11, 3'b000, 32'h0000_0202, 32'h1234_ABCD);
      checkOutput("sh_bus_we",    32'(mif.bus_we), 32'd1);
      checkOutput("sh_bus_be",    32'(mif.bus_be), 32'hC);
      checkOutput("sh_bus_wdata", mif.bus_wdata, 32'hABCD_ABCD);
      checkOutput("sh_bus_addr",  mif.bus_addr, 32'h0000_0200);
      mif.bus_ack   = 1'b1;
      mif.bus_rdata = 32'h5555_5555;
      tick();
      mif.bus_ack   = 1'b0;
      checkOutput("sh_done",  32'(mif.done), 32'd1);
      checkOutput("sh_rdata", mif.rdata, 32'h0000_7F01);
      tick();

      // Byte store into lane 1.
      applyStimulus(1'b1, 2'b01, 3'b000, 32'h0000_0301, 32'h1234_56A5);
      checkOutput("sb_bus_be",    32'(mif.bus_be), 32'h2);
      checkOutput("sb_bus_wdata", mif.bus_wdata, 32'hA5A5_A5A5);
      mif.bus_ack = 1'b1;
      tick();
      mif.bus_ack = 1'b0;
      tick();

      // Misaligned half load never touches the bus.
      applyStimulus(1'b0, 2'b00, 3'b010, 32'h0000_0201, 32'h0);
      checkOutput("mlh_bus_req",  32'(mif.bus_req), 32'd0);
      checkOutput("mlh_done",     32'(mif.done), 32'd1);
      checkOutput("mlh_misalign", 32'(mif.misalign_err), 32'd1);
      checkOutput("mlh_rdata",    mif.rdata, 32'h0000_7F01);
      tick();

      // Misaligned word store behaves the same way.
      applyStimulus(1'b1, 2'b00, 3'b000, 32'h0000_0202, 32'hFFFF_FFFF);
      checkOutput("msw_bus_req",  32'(mif.bus_req), 32'd0);
      checkOutput("msw_bus_we",   32'(mif.bus_we), 32'd0);
      checkOutput("msw_done",     32'(mif.done), 32'd1);
      checkOutput("msw_misalign", 32'(mif.misalign_err), 32'd1);
      tick();

      // No ack: bus_req stays up four cycles, then bus_err; a request during BUS is ignored.
      applyStimulus(1'b0, 2'b00, 3'b000, 32'h0000_0300, 32'h0);
      mif.req_valid = 1'b1;
      mif.addr      = 32'h0000_0400;
      high_cnt      = mif.bus_req ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!mif.bus_req) break;
         high_cnt++;
      end
      mif.req_valid = 1'b0;
      checkOutput("tmo_req_cycles", 32'(high_cnt), 32'd4);
      checkOutput("tmo_done",       32'(mif.done), 32'd1);
      checkOutput("tmo_bus_err",    32'(mif.bus_err), 32'd1);
      checkOutput("tmo_misalign",   32'(mif.misalign_err), 32'd0);
      checkOutput("tmo_rdata",      mif.rdata, 32'h0000_7F01);
      tick();
      checkOutput("busy_req_ignored", 32'(mif.bus_req), 32'd0);
      checkOutput("busy_addr_kept",   mif.bus_addr, 32'h0000_0300);

      // Reset during BUS drops everything asynchronously and yields no done.
      applyStimulus(1'b0, 2'b00, 3'b000, 32'h0000_0500, 32'h0);
      checkOutput("rb_bus_req", 32'(mif.bus_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("ra_bus_req",   32'(mif.bus_req), 32'd0);
      checkOutput("ra_req_ready", 32'(mif.req_ready), 32'd1);
      checkOutput("ra_rdata",     mif.rdata, 32'h0);
      checkOutput("ra_bus_addr",  mif.bus_addr, 32'h0);
      #1 rst = 1'b0;
      high_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (mif.done) high_cnt++;
      end
      checkOutput("ra_no_done", 32'(high_cnt), 32'd0);

      applyStimulus(1'b0, 2'b00, 3'b000, 32'h0000_0104, 32'h0);
      mif.bus_ack   = 1'b1;
      mif.bus_rdata = 32'h1234_5678;
      tick();
      mif.bus_ack   = 1'b0;
      checkOutput("post_rst_done",  32'(mif.done), 32'd1);
      checkOutput("post_rst_rdata", mif.rdata, 32'h1234_5678);
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
